interp_pwl_lut: RTL

Parametrised piecewise-linear interpolator for the 2D interpolator datapath. Maps an X_WIDTH-bit sample to a Y_WIDTH-bit result using a programmable knot table of 2^SEG_BITS+1 entries, written and read through a simple register port. It is a 3-stage pipeline with valid/ready handshakes on input and output, a software enable, and a sample counter.

---
 rtl/interp_pwl_lut.sv | 118 +++++++++++
 1 files changed

// File: rtl/interp_pwl_lut.sv
// interp_pwl_lut: 3-stage piecewise-linear interpolator over a register-programmed knot table.
// Define INTERP_ROUND_EN for round-half-up; the default build floors the interpolation step.
module interp_pwl_lut #(
    parameter int SEG_BITS   = 4,
    parameter int X_WIDTH    = 8,
    parameter int Y_WIDTH    = 10,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] i_reg_addr,
    input  logic [DATA_WIDTH-1:0] i_reg_wdata,
    input  logic                  i_reg_wr,
    input  logic                  i_reg_rd,
    output logic [DATA_WIDTH-1:0] o_reg_rdata,
    output logic                  o_reg_rvalid,
    input  logic [X_WIDTH-1:0]    i_x,
    input  logic                  i_x_valid,
    output logic                  o_x_ready,
    output logic [Y_WIDTH-1:0]    o_y,
    output logic                  o_y_valid,
    input  logic                  i_y_ready
);
    localparam int F  = X_WIDTH - SEG_BITS;
    localparam int NK = 2**SEG_BITS + 1;
    localparam int PW = Y_WIDTH + 1 + F;
    localparam logic [ADDR_WIDTH-1:0] COUNT_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR  = COUNT_ADDR - ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_KNOT  = ADDR_WIDTH'(NK - 1);
`ifdef INTERP_ROUND_EN
    localparam logic signed [PW-1:0] RND = PW'(2**(F-1));
`else
    localparam logic signed [PW-1:0] RND = '0;
`endif

    logic [Y_WIDTH-1:0]    knot [NK];
    logic                  enable;
    logic [DATA_WIDTH-1:0] count;
    logic [SEG_BITS:0]     kaddr, k0, k1;
    logic                  knot_hit, ctrl_hit, count_hit;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  adv, acc, v1, v2;
    logic [Y_WIDTH-1:0]    s1_a, s1_b, s2_a;
    logic [F-1:0]          s1_f;
    logic signed [Y_WIDTH:0] diff;
    logic signed [PW-1:0]  dx, fx, prod, s2_p, rsum, step, ysum;
    logic                  unused_wdata;

    assign unused_wdata = ^i_reg_wdata;
    assign kaddr     = i_reg_addr[SEG_BITS:0];
    assign knot_hit  = i_reg_addr <= LAST_KNOT;
    assign ctrl_hit  = i_reg_addr == CTRL_ADDR;
    assign count_hit = i_reg_addr == COUNT_ADDR;
    assign rd_mux    = knot_hit  ? DATA_WIDTH'(knot[kaddr]) :
                       ctrl_hit  ? DATA_WIDTH'(enable) :
                       count_hit ? count : '0;

    // Every stage moves together; only a stalled output blocks the pipe.
    assign adv       = !(o_y_valid && !i_y_ready);
    assign o_x_ready = enable && adv;
    assign acc       = i_x_valid && o_x_ready;
    assign k0        = {1'b0, i_x[X_WIDTH-1:F]};
    assign k1        = k0 + (SEG_BITS+1)'(1);

    assign diff = $signed({1'b0, s1_b}) - $signed({1'b0, s1_a});
    assign dx   = PW'(diff);
    assign fx   = PW'(s1_f);
    assign prod = dx * fx;
    assign rsum = s2_p + RND;
    assign step = rsum >>> F;
    assign ysum = PW'(s2_a) + step;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NK; i++) knot[i] <= '0;
            enable       <= 1'b0;
            o_reg_rdata  <= '0;
            o_reg_rvalid <= 1'b0;
        end else begin
            if (i_reg_wr && knot_hit) knot[kaddr] <= i_reg_wdata[Y_WIDTH-1:0];
            if (i_reg_wr && ctrl_hit) enable <= i_reg_wdata[0];
            o_reg_rvalid <= i_reg_rd;
            if (i_reg_rd) o_reg_rdata <= rd_mux;
        end
    end

    // A software clear takes priority over a coincident output handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) count <= '0;
        else if (i_reg_wr && count_hit) count <= '0;
        else if (o_y_valid && i_y_ready) count <= count + DATA_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_f      <= '0;
            s2_a      <= '0;
            s2_p      <= '0;
            o_y       <= '0;
            o_y_valid <= 1'b0;
        end else if (adv) begin
            v1        <= acc;
            s1_a      <= knot[k0];
            s1_b      <= knot[k1];
            s1_f      <= i_x[F-1:0];
            v2        <= v1;
            s2_a      <= s1_a;
            s2_p      <= prod;
            o_y_valid <= v2;
            if (v2) o_y <= ysum[Y_WIDTH-1:0];
        end
    end
endmodule
